// File: rtl/aes_pkg.sv
// Shared definitions for the AES decrypt controller: FSM states, datapath opcodes
// and the default key/round configuration.
package aes_pkg;

  localparam int unsigned AES_NK_DEF = 4;
  localparam int unsigned AES_NR_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_LAST  = 3'd3,
    ST_DONE  = 3'd4
  } aes_state_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_ARK  = 2'd1,
    OP_MID  = 2'd2,
    OP_LAST = 2'd3
  } aes_op_e;

endpackage

// File: rtl/aes_decrypt_ctrl_if.sv
// Block/datapath bundle of the AES decrypt controller. 128-bit blocks keep the
// first (most significant) byte of the AES block in bits [127:120].
interface aes_decrypt_ctrl_if;

  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] rnd_state;
  logic [1:0]   rnd_op;
  logic [3:0]   rk_idx;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport slave (
    input  in_valid, in_data, rnd_result, out_ready,
    output in_ready, rnd_state, rnd_op, rk_idx, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, rnd_result, out_ready,
    input  in_ready, rnd_state, rnd_op, rk_idx, out_valid, out_data, busy
  );

endinterface

// File: rtl/aes_round_ctr.sv
// Loadable 4-bit round down-counter; term_o flags the final inverse middle round.
module aes_round_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] cnt_nxt_o,
  output logic       term_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign term_o    = (cnt_q == 4'd1);

endmodule

// File: rtl/aes_decrypt_ctrl.sv
// AES inverse-cipher sequencer: walks one ciphertext block through an external round
// datapath (ARK with key NR, inverse rounds NR-1..1, last round with key 0).
module aes_decrypt_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NK = AES_NK_DEF,
  parameter int unsigned NR = AES_NR_DEF
) (
  input logic               clk,
  input logic               rst_n,
  aes_decrypt_ctrl_if.slave bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);
  localparam logic [3:0] NR_M1  = 4'(NR - 1);

  if ((NR != NK + 6) || (NR > 14)) begin : g_cfg_check
    $error("aes_decrypt_ctrl: NR must equal NK+6 and fit the 4-bit key index");
  end

  aes_state_e   state_q, state_d;
  logic [127:0] rnd_state_q, rnd_state_d;
  logic [127:0] out_data_q, out_data_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  aes_op_e      rnd_op_q, rnd_op_d;
  logic [3:0]   rk_idx_q, rk_idx_d;

  logic         ctr_load;
  logic         ctr_dec;
  logic [3:0]   ctr_cnt_nxt;
  logic         ctr_term;

  aes_round_ctr u_round_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ctr_load),
    .load_val_i (NR_M1),
    .dec_i      (ctr_dec),
    .cnt_nxt_o  (ctr_cnt_nxt),
    .term_o     (ctr_term)
  );

  // in_ready_q is low on the first cycle after reset, so acceptance needs both it and IDLE
  always_comb begin
    state_d     = state_q;
    rnd_state_d = rnd_state_q;
    out_data_d  = out_data_q;
    ctr_load    = 1'b0;
    ctr_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          rnd_state_d = bus.in_data;
          state_d     = ST_INIT;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_INIT: begin
        rnd_state_d = bus.rnd_result;
        ctr_load    = 1'b1;
        state_d     = ST_ROUND;
      end
      ST_ROUND: begin
        rnd_state_d = bus.rnd_result;
        ctr_dec     = 1'b1;
        if (ctr_term) begin
          state_d = ST_LAST;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_LAST: begin
        out_data_d = bus.rnd_result;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    rnd_op_d    = OP_NOP;
    rk_idx_d    = 4'd0;
    case (state_d)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      ST_INIT: begin
        rnd_op_d = OP_ARK;
        rk_idx_d = NR_IDX;
      end
      ST_ROUND: begin
        rnd_op_d = OP_MID;
        rk_idx_d = ctr_cnt_nxt;
      end
      ST_LAST: begin
        rnd_op_d = OP_LAST;
      end
      ST_DONE: begin
        out_valid_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rnd_state_q <= 128'd0;
      out_data_q  <= 128'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rnd_op_q    <= OP_NOP;
      rk_idx_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      rnd_state_q <= rnd_state_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rnd_op_q    <= rnd_op_d;
      rk_idx_q    <= rk_idx_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.rnd_state = rnd_state_q;
  assign bus.rnd_op    = rnd_op_q;
  assign bus.rk_idx    = rk_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Bench for aes_decrypt_ctrl: an AES-128 (NR=10) and an AES-256 (NR=14) instance, each
// driven through a behavioural AES inverse-round datapath computed from first principles.
module tb_aes_decrypt_ctrl;

  localparam int NR_A = 10;
  localparam int NR_B = 14;
  localparam logic [127:0] FIPS_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT    = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         sel;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk [0:1][0:15];

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int k);
    return s[127 - 8 * k -: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8] = isbox[gb(s, r + 4 * c)];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4 * c); a1 = gb(s, 4 * c + 1); a2 = gb(s, 4 * c + 2); a3 = gb(s, 4 * c + 3);
      o[127 - 32 * c -: 8]      = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[127 - 32 * c - 8 -: 8]  = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[127 - 32 * c - 16 -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[127 - 32 * c - 24 -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[i]  = b;
      isbox[b] = 8'(i);
    end
  endtask

  task automatic expand(input int k, input int nk, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[k][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // External round datapath seen by the controller
  function automatic logic [127:0] datapath(input logic [127:0] s, input logic [1:0] op,
                                            input logic [3:0] idx, input logic k);
    case (op)
      2'd1:    return s ^ rk[k][idx];
      2'd2:    return inv_mix(inv_sub_shift(s) ^ rk[k][idx]);
      2'd3:    return inv_sub_shift(s) ^ rk[k][idx];
      default: return s;
    endcase
  endfunction

  // Whole-block reference: FIPS-197 InvCipher loop
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int k, input int nr);
    logic [127:0] s;
    s = ct ^ rk[k][nr];
    for (int r = nr - 1; r >= 1; r--) s = inv_mix(inv_sub_shift(s) ^ rk[k][r]);
    return inv_sub_shift(s) ^ rk[k][0];
  endfunction

  // ---------------- DUTs ----------------
  aes_decrypt_ctrl_if if_a ();
  aes_decrypt_ctrl_if if_b ();

  assign if_a.in_valid   = in_valid & ~sel;
  assign if_b.in_valid   = in_valid & sel;
  assign if_a.in_data    = in_data;
  assign if_b.in_data    = in_data;
  assign if_a.out_ready  = out_ready & ~sel;
  assign if_b.out_ready  = out_ready & sel;
  assign if_a.rnd_result = datapath(if_a.rnd_state, if_a.rnd_op, if_a.rk_idx, 1'b0);
  assign if_b.rnd_result = datapath(if_b.rnd_state, if_b.rnd_op, if_b.rk_idx, 1'b1);

  aes_decrypt_ctrl #(.NK(4), .NR(NR_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  aes_decrypt_ctrl #(.NK(8), .NR(NR_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  logic         o_in_ready, o_out_valid, o_busy;
  logic [1:0]   o_op;
  logic [3:0]   o_idx;
  logic [127:0] o_out, o_state;

  always_comb begin
    if (sel) begin
      o_in_ready = if_b.in_ready; o_out_valid = if_b.out_valid; o_busy = if_b.busy;
      o_op = if_b.rnd_op; o_idx = if_b.rk_idx; o_out = if_b.out_data; o_state = if_b.rnd_state;
    end else begin
      o_in_ready = if_a.in_ready; o_out_valid = if_a.out_valid; o_busy = if_a.busy;
      o_op = if_a.rnd_op; o_idx = if_a.rk_idx; o_out = if_a.out_data; o_state = if_a.rnd_state;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, o_in_ready, 0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_rnd_op"}, o_op, 0);
    chk({tag, "_rk_idx"}, o_idx, 0);
    chk({tag, "_rnd_state"}, o_state, 0);
    chk({tag, "_out_data"}, o_out, 0);
  endtask

  // One block through the selected instance: accept, trace, latency, output hold, release
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt, input int hold,
                           input bit keep_valid, output int wait_cyc, output int acc_cyc);
    int         nr, lat, n, eop, eidx;
    logic [1:0] ops [$];
    logic [3:0] idxs [$];
    nr = sel ? NR_B : NR_A;
    in_data  = ct;
    in_valid = 1'b1;
    n = 0;
    while (!o_in_ready && n < 64) begin tick(); n++; end
    chk("accept_wait_bound", n < 64, 1);
    wait_cyc = n;
    tick();
    acc_cyc = cyc;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    if (!keep_valid) in_valid = 1'b0;
    lat = 1;
    while (!o_out_valid && lat < 64) begin
      ops.push_back(o_op);
      idxs.push_back(o_idx);
      chk("in_ready_low_while_busy", o_in_ready, 0);
      chk("busy_while_working", o_busy, 1);
      tick();
      lat++;
    end
    chk("latency_edges", lat, nr + 2);
    chk("trace_length", ops.size(), nr + 1);
    for (int p = 0; p < ops.size() && p <= nr; p++) begin
      if (p == 0) begin eop = 1; eidx = nr; end
      else if (p < nr) begin eop = 2; eidx = nr - p; end
      else begin eop = 3; eidx = 0; end
      chk("trace_rnd_op", ops[p], eop);
      chk("trace_rk_idx", idxs[p], eidx);
    end
    chk("out_data", o_out, exp_pt);
    chk("done_rnd_op_nop", o_op, 0);
    chk("done_rk_idx_zero", o_idx, 0);
    chk("done_in_ready_low", o_in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_out_valid", o_out_valid, 1);
      chk("hold_out_data", o_out, exp_pt);
      chk("hold_in_ready_low", o_in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_out_valid_low", o_out_valid, 0);
    chk("release_busy_low", o_busy, 0);
    chk("release_in_ready_high", o_in_ready, 1);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           hold;
    bit           sel;
  } vec_t;

  vec_t vt [12];

  initial begin
    int           w1, a1, w2, a2, n;
    logic [127:0] ct2;
    bit           ov_seen;

    sel = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst_n = 1'b0;
    build_sbox();
    expand(0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    expand(1, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

    vt[0] = '{FIPS_CT128, FIPS_PT, 0, 1'b0};
    vt[1] = '{FIPS_CT128, FIPS_PT, 5, 1'b0};
    vt[2] = '{FIPS_CT256, FIPS_PT, 0, 1'b1};
    for (int i = 3; i < 12; i++) begin
      vt[i].ct   = {$urandom, $urandom, $urandom, $urandom};
      vt[i].sel  = (i % 3 == 0);
      vt[i].pt   = ref_decrypt(vt[i].ct, vt[i].sel ? 1 : 0, vt[i].sel ? NR_B : NR_A);
      vt[i].hold = $urandom_range(0, 3);
    end

    repeat (2) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    #1;
    chk("in_ready_before_first_edge", o_in_ready, 0);
    tick();
    chk("in_ready_after_first_edge", o_in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      sel = vt[i].sel;
      #1;
      run_block(vt[i].ct, vt[i].pt, vt[i].hold, 1'b0, w1, a1);
    end

    // Two blocks with in_valid held high throughout
    sel = 1'b0;
    #1;
    ct2 = {$urandom, $urandom, $urandom, $urandom};
    run_block(FIPS_CT128, FIPS_PT, 0, 1'b1, w1, a1);
    run_block(ct2, ref_decrypt(ct2, 0, NR_A), 0, 1'b0, w2, a2);
    chk("b2b_second_accept_wait", w2, 0);
    chk("b2b_block_period", a2 - a1, NR_A + 3);

    // Reset in the middle of ROUND with counter at 5
    in_data = FIPS_CT128;
    in_valid = 1'b1;
    n = 0;
    while (!o_in_ready && n < 64) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!(o_op == 2'd2 && o_idx == 4'd5) && n < 40) begin tick(); n++; end
    chk("reach_round5_bound", n < 40, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    chk_all_zero("midreset_held");
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ov_seen = ov_seen | o_out_valid;
    end
    chk("no_out_valid_after_abort", ov_seen, 0);
    run_block(FIPS_CT128, FIPS_PT, 0, 1'b0, w1, a1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
